// File: rtl/lram_responder.sv
// -----------------------------------------------------------------------------
// lram_responder
//
// Valid/ready responder in front of an LRAM-style word array. Requests
// (read or write) are accepted one per cycle, travel through a fixed-depth
// registered read pipeline, and land in a first-word-fall-through response
// FIFO. Responses leave strictly in acceptance order. rsp_rdata is the array
// word as it was before the request (READ_FIRST), for reads and writes alike.
//
// The pipeline never stalls. Flow control is credit based: a request is only
// accepted when (valid pipeline stages + FIFO entries) < FIFO_DEPTH, so every
// response reaching the end of the pipeline is guaranteed a FIFO slot.
//
// Ports
//   clock_i      single clock, everything on posedge
//   reset_i      synchronous active-high reset
//   req_valid_i  request present
//   req_ready_o  a request can be accepted this cycle
//   req_addr_i   word address
//   req_wen_i    1 = write, 0 = read
//   req_wdata_i  write data (ignored for reads)
//   rsp_valid_o  response present at FIFO head
//   rsp_ready_i  initiator consumes the head response
//   rsp_rdata_o  array word before the request was applied
//   rsp_wen_o    echo of req_wen_i
//   rsp_addr_o   echo of req_addr_i
// -----------------------------------------------------------------------------
module lram_responder #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_wen_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_wen_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o
);

    localparam int WORDS   = 1 << ADDR_WIDTH;
    localparam int OCC_W   = $clog2(READ_LATENCY + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W   = CNT_W + 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    // Elaboration-time parameter sanity checks
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("lram_responder: READ_LATENCY must be in 1..4");
    end
    if (FIFO_DEPTH < READ_LATENCY) begin : g_bad_depth
        $error("lram_responder: FIFO_DEPTH must be >= READ_LATENCY");
    end

    // -------------------------------------------------------------------------
    // Array and accept
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];
    logic                  accept;

    // Pipeline stage registers, index 0 is the first stage
    logic                  st_valid_q [0:READ_LATENCY-1];
    logic                  st_wen_q   [0:READ_LATENCY-1];
    logic [ADDR_WIDTH-1:0] st_addr_q  [0:READ_LATENCY-1];
    logic [DATA_WIDTH-1:0] st_data_q  [0:READ_LATENCY-1];

    // FIFO state
    logic [ENTRY_W-1:0]    fifo_mem_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic                  push, pop;

    logic [OCC_W-1:0]      pipe_occ;
    logic [SUM_W-1:0]      credits_used;
    logic [ENTRY_W-1:0]    head;

    // Credits depend only on registered state (and reset), never on rsp_ready,
    // so a same-cycle pop frees its credit one cycle later.
    always_comb begin
        pipe_occ = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_occ = pipe_occ + OCC_W'(st_valid_q[i]);
        end
    end

    assign credits_used = SUM_W'(pipe_occ) + SUM_W'(fifo_cnt_q);
    assign req_ready_o  = !reset_i && (credits_used < SUM_W'(FIFO_DEPTH));
    assign accept       = req_valid_i && req_ready_o;

    // Array is deliberately not reset; accepted writes survive a reset.
    always_ff @(posedge clock_i) begin
        if (accept && req_wen_i) begin
            mem_q[req_addr_i] <= req_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline. The first stage samples the array on the accept edge,
    // i.e. before the write of the same request lands (READ_FIRST), while a
    // request accepted one edge later already sees that write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                st_valid_q[i] <= 1'b0;
                st_wen_q[i]   <= 1'b0;
                st_addr_q[i]  <= '0;
                st_data_q[i]  <= '0;
            end
        end else begin
            st_valid_q[0] <= accept;
            if (accept) begin
                st_wen_q[0]  <= req_wen_i;
                st_addr_q[0] <= req_addr_i;
                st_data_q[0] <= mem_q[req_addr_i];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                st_valid_q[i] <= st_valid_q[i-1];
                st_wen_q[i]   <= st_wen_q[i-1];
                st_addr_q[i]  <= st_addr_q[i-1];
                st_data_q[i]  <= st_data_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response FIFO (first-word-fall-through)
    // -------------------------------------------------------------------------
    assign push        = st_valid_q[READ_LATENCY-1];
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: it is only observed through a valid head.
    always_ff @(posedge clock_i) begin
        if (!reset_i && push) begin
            fifo_mem_q[wr_ptr_q] <= {st_wen_q[READ_LATENCY-1],
                                     st_addr_q[READ_LATENCY-1],
                                     st_data_q[READ_LATENCY-1]};
        end
    end

    // Outputs read zero whenever the FIFO is empty (including after reset).
    assign head = rsp_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
    assign {rsp_wen_o, rsp_addr_o, rsp_rdata_o} = head;

endmodule

// File: tb/tb_lram_responder.sv
// -----------------------------------------------------------------------------
// tb_lram_responder
//
// Scoreboard bench: accepted requests push their expected response (taken
// from a bench-side reference array) into a queue; a monitor pops and
// compares whenever a response is consumed. Directed sequences cover reset,
// READ_FIRST, back-to-back streaming, credit backpressure, same-address
// hazards and mid-operation reset, followed by a randomised soak.
// -----------------------------------------------------------------------------
module tb_lram_responder;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_wen;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_wen;
    logic [AW-1:0] rsp_addr;

    lram_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_wen_i  (req_wen),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_wen_o  (rsp_wen),
        .rsp_addr_o (rsp_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        bit            known;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    bit            ref_known [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;
    bit rand_rdy = 1'b0;

    bit                  hold_v = 1'b0;
    logic [1+AW+DW-1:0]  hold_val;

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_known[i] = 1'b0;
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge clock) begin
        exp_t e;
        bit   ok;
        if (reset) begin
            // Everything in flight is dropped by the reset edge.
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && rsp_valid) begin
                tests++;
                if ({rsp_wen, rsp_addr, rsp_rdata} !== hold_val) begin
                    fails++;
                    $display("[TB] FAIL hold_stable act=%h req=%h", {rsp_wen, rsp_addr, rsp_rdata}, hold_val);
                end
            end
            hold_v   = rsp_valid && !rsp_ready;
            hold_val = {rsp_wen, rsp_addr, rsp_rdata};

            if (rsp_valid && rsp_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_rsp act addr=%0d wen=%0b rdata=%h req=none", rsp_addr, rsp_wen, rsp_rdata);
                end else begin
                    e  = sb.pop_front();
                    ok = (rsp_wen === e.wen) && (rsp_addr === e.addr) &&
                         (!e.known || rsp_rdata === e.rdata);
                    if (!ok) begin
                        fails++;
                        $display("[TB] FAIL rsp act addr=%0d wen=%0b rdata=%h req addr=%0d wen=%0b rdata=%h",
                                 rsp_addr, rsp_wen, rsp_rdata, e.addr, e.wen, e.rdata);
                    end else begin
                        $display("[TB] rsp addr=%0d wen=%0b rdata=%h", rsp_addr, rsp_wen, rsp_rdata);
                    end
                end
            end

            if (req_valid && req_ready) begin
                e.wen   = req_wen;
                e.addr  = req_addr;
                e.known = ref_known[req_addr];
                e.rdata = ref_mem[req_addr];
                sb.push_back(e);
                if (req_wen) begin
                    ref_mem[req_addr]   = req_wdata;
                    ref_known[req_addr] = 1'b1;
                end
            end

            // Outstanding (accepted minus consumed) must never exceed the credits.
            tests++;
            if (sb.size() > DEPTH) begin
                fails++;
                $display("[TB] FAIL outstanding act=%0d req<=%0d", sb.size(), DEPTH);
            end
        end
    end

    // Random backpressure during the soak phase
    always @(posedge clock) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------ tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Present one request and hold it until accepted. Called just after a
    // posedge; returns just after the accept edge. waits = stalled cycles.
    task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, output int waits);
        bit acc = 1'b0;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_valid = 1'b1;
        waits     = 0;
        while (!acc && waits < 100) begin
            @(negedge clock);
            if (req_ready && !reset) acc = 1'b1;
            else waits++;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("[TB] FAIL req_timeout act=not_accepted req=accepted addr=%0d", a);
        end
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int w;
        reset     = 1'b1;
        req_valid = 1'b1;       // must be ignored while in reset
        req_addr  = 3'd1;
        req_wen   = 1'b1;
        req_wdata = 8'hEE;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_wen",   rsp_wen, 0);
        chk("rst_rsp_addr",  rsp_addr, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);
        @(posedge clock);
        #1;

        // 1: write 0x77 @3 then read @3
        rsp_ready = 1'b1;
        do_req(3'd3, 1'b1, 8'h77, w);
        do_req(3'd3, 1'b0, 8'h00, w);
        drain();

        // 2: back-to-back writes then reads, one accept per cycle
        for (int a = 0; a < 8; a++) begin
            do_req(3'(a), 1'b1, 8'(8'h10 + a), w);
            chk("b2b_wr_stall", w, 0);
        end
        for (int a = 0; a < 8; a++) begin
            do_req(3'(a), 1'b0, 8'h00, w);
            chk("b2b_rd_stall", w, 0);
        end
        drain();

        // Latency: accept edge k -> rsp_valid after edge k+2
        do_req(3'd0, 1'b0, 8'h00, w);
        @(negedge clock); chk("lat_after_k",   rsp_valid, 0);
        @(negedge clock); chk("lat_after_k1",  rsp_valid, 0);
        @(negedge clock); chk("lat_after_k2",  rsp_valid, 1);
        @(posedge clock);
        #1;
        drain();

        // 3: backpressure, credits exhaust at FIFO_DEPTH
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(3'(i), 1'b0, 8'h00, w);
            chk("fill_stall", w, 0);
        end
        req_addr  = 3'd7;
        req_wen   = 1'b0;
        req_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("full_ready", req_ready, 0);
            @(posedge clock);
            #1;
        end
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_head_addr", rsp_addr, 0);
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("no_early_credit", req_ready, 0);
        @(posedge clock);       // first pop
        #1;
        @(negedge clock);
        chk("credit_back", req_ready, 1);
        @(posedge clock);       // fifth request accepted here
        #1;
        req_valid = 1'b0;
        drain();

        // 4: write 0xAA @5 then read @5 on the very next edge
        do_req(3'd5, 1'b1, 8'hAA, w);
        do_req(3'd5, 1'b0, 8'h00, w);
        chk("hazard_stall", w, 0);
        drain();

        // 5: reset with 3 queued responses and 1 in the pipeline
        rsp_ready = 1'b0;
        do_req(3'd6, 1'b1, 8'h5C, w);
        do_req(3'd1, 1'b0, 8'h00, w);
        do_req(3'd2, 1'b0, 8'h00, w);
        do_req(3'd4, 1'b0, 8'h00, w);
        @(posedge clock);
        #1;
        chk("pre_rst_queued", rsp_valid, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("mid_rst_no_rsp", rsp_valid, 0);
            @(posedge clock);
            #1;
        end
        do_req(3'd6, 1'b0, 8'h00, w);   // expects 0x5C survived reset
        drain();

        // 6: randomised soak against the reference model
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            do_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), w);
        end
        rand_rdy = 1'b0;
        @(posedge clock);
        #2;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #900000;
        $display("[TB] FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
